// File: rtl/stream_demux_pkg.sv
// Shared types and sizes for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } demux_state_t;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot. Can be drained and refilled in the
// same cycle, so a single slot sustains one beat per cycle.
module demux_out_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             free
);

  // The slot can take a beat if it is empty or is being drained right now.
  assign free = !out_valid || out_ready;

  // Load wins over drain; payload only changes on load so it stays stable
  // while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer. The destination is taken from
// in_sel on the first beat of a packet and held until the last beat.
//
// state  | meaning
// IDLE   | between packets; route follows in_sel
// LOCKED | inside a multi-beat packet; route follows sel_q
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_last,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [N_OUT-1:0] out_last,
  output logic             pkt_active
);

  demux_state_t     state;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] route;
  logic [N_OUT-1:0] slot_free;
  logic [N_OUT-1:0] load;
  logic [WIDTH-1:0] slot_data [N_OUT];
  logic             accept;

  // in_ready is deliberately combinational from out_ready and in_sel so a
  // draining slot can be refilled in the same cycle; it ignores in_valid.
  assign route      = (state == LOCKED) ? sel_q : in_sel;
  assign in_ready   = !rst && slot_free[route];
  assign accept     = in_valid && in_ready;
  assign pkt_active = (state == LOCKED);

  // Packet framing: lock the destination on a non-final first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!in_last) begin
            state <= LOCKED;
            sel_q <= in_sel;
          end
        end
        LOCKED: begin
          if (in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    assign load[i] = accept && (route == SEL_W'(i));

    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .load_data (in_data),
      .load_last (in_last),
      .out_ready (out_ready[i]),
      .out_valid (out_valid[i]),
      .out_data  (slot_data[i]),
      .out_last  (out_last[i]),
      .free      (slot_free[i])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed scenarios on a WIDTH=4 instance and
// random traffic shared by WIDTH=1, 4 and 8 instances against a packet model.
module tb_stream_demux_1_4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_last;
  logic [3:0] out_ready;

  logic       rdy1, rdy4, rdy8;
  logic [3:0] v1, v4, v8;
  logic [3:0] l1, l4, l8;
  logic       pa1, pa4, pa8;
  logic [0:0] d1 [4];
  logic [3:0] d4 [4];
  logic [7:0] d8 [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux_1_4 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data[0:0]), .in_sel(in_sel), .in_last(in_last),
    .out_valid(v1), .out_ready(out_ready),
    .out_data0(d1[0]), .out_data1(d1[1]), .out_data2(d1[2]), .out_data3(d1[3]),
    .out_last(l1), .pkt_active(pa1));

  stream_demux_1_4 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data[3:0]), .in_sel(in_sel), .in_last(in_last),
    .out_valid(v4), .out_ready(out_ready),
    .out_data0(d4[0]), .out_data1(d4[1]), .out_data2(d4[2]), .out_data3(d4[3]),
    .out_last(l4), .pkt_active(pa4));

  stream_demux_1_4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .out_valid(v8), .out_ready(out_ready),
    .out_data0(d8[0]), .out_data1(d8[1]), .out_data2(d8[2]), .out_data3(d8[3]),
    .out_last(l8), .pkt_active(pa8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    in_last  = l;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 4'hF;
    drive(1'b1, 2'd1, 8'h5, 1'b0);
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", rdy4); end
    tick();
    checks++; if (v4 !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b want 0000", v4); end
    checks++; if (l4 !== 4'b0000) begin errors++; $display("FAIL reset_out_last got %b want 0000", l4); end
    checks++; if (pa4 !== 1'b0) begin errors++; $display("FAIL reset_pkt_active got %b want 0", pa4); end
    checks++;
    if ({d4[0], d4[1], d4[2], d4[3]} !== 16'h0) begin
      errors++; $display("FAIL reset_out_data got %h want 0000", {d4[0], d4[1], d4[2], d4[3]});
    end
  endtask

  task automatic test_single_beat();
    rst = 1'b0; out_ready = 4'hF;
    drive(1'b1, 2'd2, 8'hA, 1'b1);
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", rdy4); end
    tick();
    drive(1'b0, 2'd0, 8'h0, 1'b0);
    checks++; if (v4 !== 4'b0100) begin errors++; $display("FAIL single_out_valid got %b want 0100", v4); end
    checks++; if (d4[2] !== 4'hA) begin errors++; $display("FAIL single_data2 got %h want a", d4[2]); end
    checks++; if (l4[2] !== 1'b1) begin errors++; $display("FAIL single_last2 got %b want 1", l4[2]); end
    checks++; if (pa4 !== 1'b0) begin errors++; $display("FAIL single_pkt_active got %b want 0", pa4); end
    tick();
    checks++; if (v4 !== 4'b0000) begin errors++; $display("FAIL single_drain got %b want 0000", v4); end
  endtask

  task automatic test_locked_route();
    logic [1:0] sel_seq [3];
    sel_seq[0] = 2'd1; sel_seq[1] = 2'd3; sel_seq[2] = 2'd3;
    out_ready = 4'hF;
    for (int b = 0; b < 3; b++) begin
      drive(1'b1, sel_seq[b], 8'(b + 1), (b == 2));
      tick();
      checks++; if (v4 !== 4'b0010) begin errors++; $display("FAIL locked_valid beat%0d got %b want 0010", b, v4); end
      checks++; if (d4[1] !== 4'(b + 1)) begin errors++; $display("FAIL locked_data1 beat%0d got %h want %h", b, d4[1], b + 1); end
      checks++; if (pa4 !== (b != 2)) begin errors++; $display("FAIL locked_pkt_active beat%0d got %b want %b", b, pa4, b != 2); end
    end
    checks++; if (l4[1] !== 1'b1) begin errors++; $display("FAIL locked_last1 got %b want 1", l4[1]); end
    drive(1'b0, 2'd0, 8'h0, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1110;
    drive(1'b1, 2'd0, 8'h5, 1'b0);
    tick();
    checks++; if (v4[0] !== 1'b1 || d4[0] !== 4'h5) begin errors++; $display("FAIL bp_first got v=%b d=%h want v=1 d=5", v4[0], d4[0]); end
    checks++; if (pa4 !== 1'b1) begin errors++; $display("FAIL bp_pkt_active got %b want 1", pa4); end
    drive(1'b1, 2'd2, 8'h6, 1'b0);
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b want 0", rdy4); end
    tick();
    checks++; if (v4[0] !== 1'b1 || d4[0] !== 4'h5) begin errors++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=5", v4[0], d4[0]); end
    out_ready = 4'hF;
    #1;
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", rdy4); end
    tick();
    checks++; if (v4 !== 4'b0001 || d4[0] !== 4'h6) begin errors++; $display("FAIL bp_beat2 got v=%b d=%h want v=0001 d=6", v4, d4[0]); end
    drive(1'b1, 2'd3, 8'h7, 1'b1);
    tick();
    checks++; if (v4 !== 4'b0001 || d4[0] !== 4'h7 || l4[0] !== 1'b1) begin
      errors++; $display("FAIL bp_beat3 got v=%b d=%h l=%b want v=0001 d=7 l=1", v4, d4[0], l4[0]);
    end
    drive(1'b0, 2'd0, 8'h0, 1'b0);
    tick();
    checks++; if (v4 !== 4'b0000) begin errors++; $display("FAIL bp_drain got %b want 0000", v4); end
  endtask

  task automatic test_independent_drain();
    out_ready = 4'b1110;
    drive(1'b1, 2'd0, 8'h9, 1'b1);
    tick();
    drive(1'b1, 2'd3, 8'hC, 1'b1);
    tick();
    checks++; if (v4 !== 4'b1001) begin errors++; $display("FAIL indep_loaded got %b want 1001", v4); end
    drive(1'b0, 2'd0, 8'h0, 1'b0);
    tick();
    checks++; if (v4 !== 4'b0001 || d4[0] !== 4'h9) begin errors++; $display("FAIL indep_drain3 got v=%b d0=%h want v=0001 d0=9", v4, d4[0]); end
    drive(1'b1, 2'd3, 8'hD, 1'b1);
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL indep_ready3 got %b want 1", rdy4); end
    tick();
    checks++; if (v4 !== 4'b1001 || d4[3] !== 4'hD || d4[0] !== 4'h9) begin
      errors++; $display("FAIL indep_reload got v=%b d3=%h d0=%h want v=1001 d3=d d0=9", v4, d4[3], d4[0]);
    end
    out_ready = 4'hF;
    drive(1'b0, 2'd0, 8'h0, 1'b0);
    tick();
  endtask

  task automatic test_mid_packet_reset();
    out_ready = 4'hF;
    drive(1'b1, 2'd2, 8'h1, 1'b0);
    tick();
    drive(1'b1, 2'd2, 8'h2, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 2'd2, 8'h3, 1'b0);
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL mrst_ready got %b want 0", rdy4); end
    tick();
    checks++; if (v4 !== 4'b0000 || pa4 !== 1'b0) begin errors++; $display("FAIL mrst_state got v=%b pa=%b want v=0000 pa=0", v4, pa4); end
    rst = 1'b0;
    drive(1'b1, 2'd1, 8'h4, 1'b1);
    tick();
    checks++; if (v4 !== 4'b0010 || d4[1] !== 4'h4) begin errors++; $display("FAIL mrst_newpkt got v=%b d1=%h want v=0010 d1=4", v4, d4[1]); end
    drive(1'b0, 2'd0, 8'h0, 1'b0);
    tick();
  endtask

  // Packet-level model: each output holds at most one beat; a packet's
  // beats all go to the output named by its first beat.
  task automatic test_random_traffic();
    logic       m_valid [4];
    logic [7:0] m_data  [4];
    logic       m_last  [4];
    logic       in_pkt;
    int         pkt_dest;
    int         dest;
    logic       exp_ready;
    logic [3:0] exp_valid;
    int         accepted = 0;
    int         delivered = 0;

    rst = 1'b1; out_ready = 4'hF;
    drive(1'b0, 2'd0, 8'h0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin m_valid[i] = 1'b0; m_data[i] = '0; m_last[i] = 1'b0; end
    in_pkt = 1'b0; pkt_dest = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) out_ready[i] = ($urandom_range(3) != 0);
      drive($urandom_range(3) != 0, 2'($urandom_range(3)), 8'($urandom), $urandom_range(2) == 0);

      for (int i = 0; i < 4; i++) exp_valid[i] = m_valid[i];
      checks++; if (v1 !== exp_valid || v4 !== exp_valid || v8 !== exp_valid) begin
        errors++; $display("FAIL rnd_valid cyc%0d got %b/%b/%b want %b", cyc, v1, v4, v8, exp_valid);
      end
      checks++; if (pa1 !== in_pkt || pa4 !== in_pkt || pa8 !== in_pkt) begin
        errors++; $display("FAIL rnd_pkt_active cyc%0d got %b/%b/%b want %b", cyc, pa1, pa4, pa8, in_pkt);
      end
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i]) begin
          checks++;
          if (d8[i] !== m_data[i] || d4[i] !== m_data[i][3:0] || d1[i] !== m_data[i][0:0] ||
              l1[i] !== m_last[i] || l4[i] !== m_last[i] || l8[i] !== m_last[i]) begin
            errors++;
            $display("FAIL rnd_data%0d cyc%0d got %h/%h/%h last %b/%b/%b want %h last %b",
                     i, cyc, d1[i], d4[i], d8[i], l1[i], l4[i], l8[i], m_data[i], m_last[i]);
          end
          if (v8[i] && out_ready[i]) delivered++;
        end
      end

      dest = in_pkt ? pkt_dest : int'(in_sel);
      exp_ready = !m_valid[dest] || out_ready[dest];
      checks++; if (rdy1 !== exp_ready || rdy4 !== exp_ready || rdy8 !== exp_ready) begin
        errors++; $display("FAIL rnd_in_ready cyc%0d got %b/%b/%b want %b", cyc, rdy1, rdy4, rdy8, exp_ready);
      end

      for (int i = 0; i < 4; i++) if (out_ready[i]) m_valid[i] = 1'b0;
      if (in_valid && exp_ready) begin
        accepted++;
        m_valid[dest] = 1'b1;
        m_data[dest]  = in_data;
        m_last[dest]  = in_last;
        pkt_dest      = dest;
        in_pkt        = !in_last;
      end
      tick();
    end

    out_ready = 4'hF;
    drive(1'b0, 2'd0, 8'h0, 1'b0);
    for (int i = 0; i < 4; i++) if (v8[i]) delivered++;
    tick();
    checks++; if (v8 !== 4'b0000) begin errors++; $display("FAIL rnd_final_drain got %b want 0000", v8); end
    checks++; if (delivered !== accepted) begin errors++; $display("FAIL rnd_beat_count got %0d want %0d", delivered, accepted); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0; out_ready = 4'hF;
    test_reset();
    test_single_beat();
    test_locked_route();
    test_backpressure();
    test_independent_drain();
    test_mid_packet_reset();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- Registered 1-to-4 stream demultiplexer; the distributing counterpart of the 4:1 data muxes in the combinational library.
- Routes each beat of one valid/ready input stream to one of four output streams.
- The route is selected by in_sel on the first beat of a packet and held until in_last.
- Each output has a one-entry register slot, so outputs are registered and each sustains full throughput.

Parameters:
- WIDTH, 4, data width of the input and of each output stream; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid is also high.
- in_data  input  WIDTH  input payload.
- in_sel  input  2  destination output index; sampled only on the first beat of a packet.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  4  bit i means output i holds a beat.
- out_ready  input  4  bit i means the output i consumer accepts this cycle.
- out_data0, out_data1, out_data2, out_data3  output  WIDTH each  payload of outputs 0 to 3.
- out_last  output  4  bit i is the last flag of the beat held on output i.
- pkt_active  output  1  high while a multi-beat packet is in progress (state LOCKED).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_last=0, all out_dataN=0, pkt_active=0, state=IDLE, sel_q=0.
- in_ready is forced to 0 while rst=1.
- Slot i (registered): valid_q[i], data_q[i], last_q[i]; drives out_valid[i], out_dataN, out_last[i].
- slot_free[i] = !valid_q[i] || out_ready[i]. The consumer drains the slot in the same cycle it is refilled.
- route = (state==LOCKED) ? sel_q : in_sel.
- in_ready = !rst && slot_free[route]. This is a combinational path from out_ready and in_sel; it is permitted and documented. in_ready must not depend on in_valid.
- Accept = in_valid && in_ready. On accept, slot[route] loads in_data and in_last, and valid_q[route] is set.
- Latency: an accepted beat appears on its output in the next cycle. Throughput is 1 beat/cycle while the destination is ready.
- Slot i clears valid when out_ready[i] && valid_q[i] and there is no load into slot i that cycle. A simultaneous drain and load keeps valid=1 with the new data.
- While out_valid[i]=1 and out_ready[i]=0, out_dataN and out_last[i] are held stable.
- Non-routed slots drain independently every cycle; there is no head-of-line coupling except through in_ready.
- FSM, states IDLE and LOCKED:
  - IDLE: on accept with in_last=0, go to LOCKED and set sel_q<=in_sel. On accept with in_last=1 (single-beat packet), stay in IDLE.
  - LOCKED: in_sel is ignored. On accept with in_last=1, go to IDLE. Otherwise stay in LOCKED.
- pkt_active = (state==LOCKED).
- A change of in_sel in the middle of a packet has no effect on routing.
- Mid-packet reset returns the block to IDLE. Contents of all slots are discarded (out_valid=0 in the cycle after rst is sampled high).
- in_valid=0 never changes state, regardless of in_sel or in_last.
- WIDTH=1 is legal and must behave identically.

Decomposition:
- Package stream_demux_pkg:
  - typedef enum logic {IDLE, LOCKED} demux_state_t
  - localparam N_OUT = 4
  - localparam SEL_W = 2
- Sub-module demux_out_slot, instantiated 4 times:
  - Parameter WIDTH.
  - Inputs: clk, rst, load, load_data, load_last, out_ready.
  - Outputs: out_valid, out_data, out_last, free.
- The top level contains the FSM, sel_q, route decode and the in_ready mux.

Test Plan:
- Single-beat packets: in_sel=2, data=4'hA, last=1, all out_ready=1 -> next cycle out_valid=4'b0100, out_data2=A, out_last[2]=1, pkt_active stays 0.
- Three-beat packet to output 1 (data 1,2,3), with in_sel toggled to 3 on beats 2-3 -> all three beats appear on out_data1 in order, pkt_active=1 after beat 1 and 0 after beat 3, out_valid[3] never set.
- Back-pressure: packet to output 0 with out_ready[0]=0 -> first beat is held, in_ready=0 on the next beat, out_data0 stable. Raise out_ready[0] -> in_ready=1 in the same cycle and the beat streams at 1/cycle with no loss or duplicate.
- Independent drain: load outputs 0 and 3, stall output 0, keep out_ready[3]=1 -> output 3 empties next cycle. A new packet to output 3 is accepted while output 0 remains stalled.
- Mid-packet reset: assert rst after beat 2 of a 4-beat packet to output 2 -> the cycle after, out_valid=0, pkt_active=0, in_ready=0 during rst. After release, a new packet with in_sel=1 routes to output 1.
- Random traffic at WIDTH=1 and WIDTH=8 against a scoreboard -> per-output ordering preserved, no drops or duplicates, and every packet lands on its first-beat in_sel.
